eth_tx_frame_arbiter: RTL and testbench

Frame-granular round-robin arbiter that shares the single 10G MAC TX AXI-Stream input among up to `S_COUNT` requesters. It sits in the `tx_clk` domain, directly in front of the `tx_axis_*` port of `eth_mac_10g_fifo`. It never interleaves beats of different frames. It also enforces a maximum frame length: an over-length frame is truncated and marked bad, and the remainder of that frame is discarded.

---
 rtl/eth_tx_frame_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the 10G MAC TX stream.
// Frames are never interleaved; over-length frames are cut, flagged bad, and their tail discarded.
module eth_tx_frame_arbiter #(
  parameter int S_COUNT        = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int KEEP_WIDTH     = DATA_WIDTH/8,
  parameter int USER_WIDTH     = 1,
  parameter int MAX_BEATS      = 1152,
  parameter int BEAT_CNT_WIDTH = $clog2(MAX_BEATS+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    grant_index,
  output logic                          trunc_pulse
);

  localparam int IDX_W = $clog2(S_COUNT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

  localparam logic [BEAT_CNT_WIDTH-1:0] CNT_LAST = BEAT_CNT_WIDTH'(MAX_BEATS-1);

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic [IDX_W-1:0]          lastg_q, lastg_d;
  logic [BEAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      trunc_q, trunc_d;

  logic [DATA_WIDTH-1:0]     mdata_q, mdata_d;
  logic [KEEP_WIDTH-1:0]     mkeep_q, mkeep_d;
  logic [USER_WIDTH-1:0]     muser_q, muser_d;
  logic                      mvalid_q, mvalid_d;
  logic                      mlast_q, mlast_d;

  logic [DATA_WIDTH-1:0]     port_data [S_COUNT];
  logic [KEEP_WIDTH-1:0]     port_keep [S_COUNT];
  logic [USER_WIDTH-1:0]     port_user [S_COUNT];

  logic                      port_rdy;
  logic                      sel_valid, sel_last;
  logic [USER_WIDTH-1:0]     sel_user;
  logic                      xfer, load, force_end;
  logic                      rr_found;
  logic [IDX_W-1:0]          rr_idx;
  int                        rr_p;

  for (genvar i = 0; i < S_COUNT; i++) begin : g_port
    assign port_data[i]     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign port_keep[i]     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
    assign port_user[i]     = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
    assign s_axis_tready[i] = port_rdy && (grant_q == IDX_W'(i));
  end

  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign xfer      = port_rdy && sel_valid;

  // The only combinational input-to-output path: ready follows m_axis_tready while ACTIVE.
  always_comb begin
    port_rdy = 1'b0;
    case (state_q)
      ST_ACTIVE: port_rdy = !mvalid_q || m_axis_tready;
      ST_DROP:   port_rdy = 1'b1;
      default:   port_rdy = 1'b0;
    endcase
  end

  // First requester strictly after the previous winner, wrapping modulo S_COUNT.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_p     = 0;
    for (int k = 1; k <= S_COUNT; k++) begin
      rr_p = int'(lastg_q) + k;
      if (rr_p >= S_COUNT) rr_p = rr_p - S_COUNT;
      if (!rr_found && s_axis_tvalid[rr_p]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(rr_p);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    lastg_d   = lastg_q;
    cnt_d     = cnt_q;
    trunc_d   = 1'b0;
    load      = 1'b0;
    force_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_d = rr_idx;
          cnt_d   = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (xfer) begin
          load  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (sel_last) begin
            state_d = ST_IDLE;
            lastg_d = grant_q;
          end else if (cnt_q == CNT_LAST) begin
            force_end = 1'b1;
            trunc_d   = 1'b1;
            state_d   = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (xfer && sel_last) begin
          state_d = ST_IDLE;
          lastg_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A truncated beat closes the frame downstream and marks it bad.
  always_comb begin
    sel_user    = port_user[grant_q];
    sel_user[0] = sel_user[0] | force_end;
  end

  always_comb begin
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    mkeep_d  = mkeep_q;
    mlast_d  = mlast_q;
    muser_d  = muser_q;
    if (load) begin
      mvalid_d = 1'b1;
      mdata_d  = port_data[grant_q];
      mkeep_d  = port_keep[grant_q];
      mlast_d  = sel_last | force_end;
      muser_d  = sel_user;
    end else if (m_axis_tready) begin
      mvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      lastg_q  <= IDX_W'(S_COUNT-1);
      cnt_q    <= '0;
      trunc_q  <= 1'b0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mkeep_q  <= '0;
      mlast_q  <= 1'b0;
      muser_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      lastg_q  <= lastg_d;
      cnt_q    <= cnt_d;
      trunc_q  <= trunc_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mkeep_q  <= mkeep_d;
      mlast_q  <= mlast_d;
      muser_q  <= muser_d;
    end
  end

  assign m_axis_tdata  = mdata_q;
  assign m_axis_tkeep  = mkeep_q;
  assign m_axis_tvalid = mvalid_q;
  assign m_axis_tlast  = mlast_q;
  assign m_axis_tuser  = muser_q;
  assign grant_valid   = (state_q != ST_IDLE);
  assign grant_index   = grant_q;
  assign trunc_pulse   = trunc_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter: per-port frame queues feed two instances (long and short
// frame limit); a frame-level model predicts grant order, ready, and the output beat stream.
module tb_eth_tx_frame_arbiter;
  localparam int S = 4, DW = 64, KW = 8, UW = 1;
  localparam int MAXA = 16, MAXB = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct {
    logic [S-1:0] mask;
    int           exp_grant;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [S*DW-1:0] s_tdata;
  logic [S*KW-1:0] s_tkeep;
  logic [S-1:0]    s_tvalid, s_tlast;
  logic [S*UW-1:0] s_tuser;
  logic            m_tready;
  logic            sel4;

  logic [S-1:0]  tv_a, tv_b, rdy_a, rdy_b;
  logic          mt_a, mt_b;
  logic [DW-1:0] md_a, md_b;
  logic [KW-1:0] mk_a, mk_b;
  logic          mv_a, mv_b, ml_a, ml_b, gv_a, gv_b, tp_a, tp_b;
  logic [UW-1:0] mu_a, mu_b;
  logic [1:0]    gi_a, gi_b;

  assign tv_a = sel4 ? '0 : s_tvalid;
  assign tv_b = sel4 ? s_tvalid : '0;
  assign mt_a = sel4 ? 1'b1 : m_tready;
  assign mt_b = sel4 ? m_tready : 1'b1;

  eth_tx_frame_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_BEATS(MAXA)) dut_a (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(tv_a),
    .s_axis_tready(rdy_a), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tdata(md_a),
    .m_axis_tkeep(mk_a), .m_axis_tvalid(mv_a), .m_axis_tready(mt_a), .m_axis_tlast(ml_a),
    .m_axis_tuser(mu_a), .grant_valid(gv_a), .grant_index(gi_a), .trunc_pulse(tp_a));

  eth_tx_frame_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_BEATS(MAXB)) dut_b (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(tv_b),
    .s_axis_tready(rdy_b), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tdata(md_b),
    .m_axis_tkeep(mk_b), .m_axis_tvalid(mv_b), .m_axis_tready(mt_b), .m_axis_tlast(ml_b),
    .m_axis_tuser(mu_b), .grant_valid(gv_b), .grant_index(gi_b), .trunc_pulse(tp_b));

  logic [S-1:0]  mon_rdy;
  logic [DW-1:0] mon_data;
  logic [KW-1:0] mon_keep;
  logic          mon_valid, mon_last, mon_user, mon_gv, mon_trunc;
  logic [1:0]    mon_gi;
  assign mon_rdy   = sel4 ? rdy_b : rdy_a;
  assign mon_data  = sel4 ? md_b : md_a;
  assign mon_keep  = sel4 ? mk_b : mk_a;
  assign mon_valid = sel4 ? mv_b : mv_a;
  assign mon_last  = sel4 ? ml_b : ml_a;
  assign mon_user  = sel4 ? mu_b[0] : mu_a[0];
  assign mon_gv    = sel4 ? gv_b : gv_a;
  assign mon_gi    = sel4 ? gi_b : gi_a;
  assign mon_trunc = sel4 ? tp_b : tp_a;

  beat_t pq[S][$];
  beat_t exq[$];
  beat_t out_log[$];
  int    gi_log[$];
  int    checks = 0, failures = 0;
  int    model_last, cur_port, cur_acc, exp_trunc, seen_trunc, out_cnt, cyc, first_tv, first_mv;
  bit    busy, prev_busy, gaps, bp_rand, toggle_mode, tog, keep_only;
  logic [S-1:0] prev_tv;
  vec_t  vecs[12];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int maxb();
    return sel4 ? MAXB : MAXA;
  endfunction

  function automatic int rr_pick(int last, logic [S-1:0] v);
    for (int k = 1; k <= S; k++)
      if (v[(last + k) % S]) return (last + k) % S;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < S; i++) if (pq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_frame(int p, int len, logic [63:0] base, logic [7:0] last_keep, bit rnd);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = rnd ? {$urandom, $urandom} : base + 64'(k);
      b.keep = rnd ? 8'($urandom_range(1, 255)) : ((k == len-1) ? last_keep : 8'hFF);
      b.user = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      b.last = (k == len-1);
      pq[p].push_back(b);
    end
  endtask

  // Expected output of a granted frame: first MAX beats, the MAX-th closed and marked bad.
  task automatic start_frame(int g);
    int len, mx;
    beat_t b;
    mx = maxb();
    busy = 1; cur_port = g; cur_acc = 0; model_last = g;
    gi_log.push_back(int'(mon_gi));
    len = pq[g].size();
    for (int k = 0; k < pq[g].size(); k++)
      if (pq[g][k].last) begin len = k + 1; break; end
    for (int k = 0; k < len && k < mx; k++) begin
      b = pq[g][k];
      if (len > mx && k == mx-1) begin b.last = 1'b1; b.user = 1'b1; end
      exq.push_back(b);
    end
    if (len > mx) exp_trunc++;
    if (keep_only) for (int i = 0; i < S; i++) if (i != g) pq[i].delete();
  endtask

  task automatic tick();
    logic [S-1:0] rdy_exp, acc;
    int g;
    beat_t e, b;
    @(negedge clk);
    for (int i = 0; i < S; i++) begin
      if (pq[i].size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
        s_tvalid[i] = 1'b1; s_tlast[i] = pq[i][0].last;
        s_tdata[i*DW +: DW] = pq[i][0].data; s_tkeep[i*KW +: KW] = pq[i][0].keep;
        s_tuser[i*UW +: UW] = pq[i][0].user;
      end else begin
        s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0;
        s_tdata[i*DW +: DW] = '0; s_tkeep[i*KW +: KW] = '0; s_tuser[i*UW +: UW] = '0;
      end
    end
    if (bp_rand) m_tready = ($urandom_range(0, 2) != 0);
    else if (toggle_mode) begin m_tready = tog; tog = !tog; end
    else m_tready = 1'b1;
    #1;
    if (s_tvalid != 0 && first_tv < 0) first_tv = cyc;
    if (mon_valid && first_mv < 0) first_mv = cyc;
    if (!busy) begin
      if (!prev_busy && prev_tv != 0) begin
        g = rr_pick(model_last, prev_tv);
        chk("grant_valid_rise", 64'(mon_gv), 64'(1));
        chk("grant_index", 64'(mon_gi), 64'(g));
        start_frame(g);
      end else chk("grant_valid_idle", 64'(mon_gv), 64'(0));
    end else chk("grant_valid_hold", 64'(mon_gv), 64'(1));
    rdy_exp = '0;
    if (busy) rdy_exp[cur_port] = (cur_acc < maxb()) ? (!mon_valid || m_tready) : 1'b1;
    chk("s_tready", 64'(mon_rdy), 64'(rdy_exp));
    acc = s_tvalid & mon_rdy;
    if (mon_valid && m_tready) begin
      out_cnt++;
      b.data = mon_data; b.keep = mon_keep; b.last = mon_last; b.user = mon_user;
      out_log.push_back(b);
      chk("out_pending", 64'(exq.size() > 0), 64'(1));
      if (exq.size() > 0) begin
        e = exq.pop_front();
        chk("m_tdata", mon_data, e.data);
        chk("m_tkeep", 64'(mon_keep), 64'(e.keep));
        chk("m_tlast", 64'(mon_last), 64'(e.last));
        chk("m_tuser", 64'(mon_user), 64'(e.user));
      end
    end
    if (mon_trunc) seen_trunc++;
    prev_busy = busy; prev_tv = s_tvalid;
    @(posedge clk);
    for (int i = 0; i < S; i++) begin
      if (acc[i] && pq[i].size() > 0) begin
        b = pq[i].pop_front();
        if (busy && i == cur_port) begin
          cur_acc++;
          if (b.last) busy = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic run_until_idle(int budget, string name);
    int n;
    n = 0;
    while (n < budget && !(all_empty() && !busy && exq.size() == 0)) begin tick(); n++; end
    chk({name, "_complete"}, 64'(n < budget), 64'(1));
    tick();
    chk({name, "_trunc_count"}, 64'(seen_trunc), 64'(exp_trunc));
  endtask

  task automatic reset_model();
    for (int i = 0; i < S; i++) pq[i].delete();
    exq.delete(); out_log.delete(); gi_log.delete();
    busy = 0; prev_busy = 0; prev_tv = '0; model_last = S-1; cur_port = 0; cur_acc = 0;
    exp_trunc = 0; seen_trunc = 0; out_cnt = 0; cyc = 0; first_tv = -1; first_mv = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, prev;
    vecs[0]  = '{4'b1111, 0}; vecs[1]  = '{4'b1111, 1}; vecs[2]  = '{4'b0101, 2};
    vecs[3]  = '{4'b0101, 0}; vecs[4]  = '{4'b1000, 3}; vecs[5]  = '{4'b0011, 0};
    vecs[6]  = '{4'b1010, 1}; vecs[7]  = '{4'b1001, 3}; vecs[8]  = '{4'b0110, 1};
    vecs[9]  = '{4'b0001, 0}; vecs[10] = '{4'b1100, 2}; vecs[11] = '{4'b0011, 0};
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b1;
    sel4 = 1'b0; gaps = 0; bp_rand = 0; toggle_mode = 0; tog = 1; keep_only = 0;

    // reset state
    do_reset();
    #1;
    chk("rst_m_tvalid", 64'(mon_valid), 64'(0));
    chk("rst_m_tlast", 64'(mon_last), 64'(0));
    chk("rst_m_tuser", 64'(mon_user), 64'(0));
    chk("rst_m_tdata", mon_data, 64'(0));
    chk("rst_m_tkeep", 64'(mon_keep), 64'(0));
    chk("rst_s_tready", 64'(mon_rdy), 64'(0));
    chk("rst_grant_valid", 64'(mon_gv), 64'(0));
    chk("rst_grant_index", 64'(mon_gi), 64'(0));
    chk("rst_trunc_pulse", 64'(mon_trunc), 64'(0));

    // single port, 3 beats, short last beat
    push_frame(0, 3, 64'h1000, 8'h0F, 0);
    run_until_idle(50, "single");
    chk("single_latency", 64'(first_mv - first_tv), 64'(2));
    chk("single_beats", 64'(out_cnt), 64'(3));
    chk("single_last_keep", 64'(out_log[2].keep), 64'(8'h0F));

    // round-robin vector table, one-beat frames, losers withdrawn after each grant
    do_reset();
    keep_only = 1;
    for (int r = 0; r < 12; r++) begin
      for (int p = 0; p < S; p++)
        if (vecs[r].mask[p]) push_frame(p, 1, 64'hC0DE_0000_0000_0000 + 64'(r*16 + p), 8'hFF, 0);
      prev = gi_log.size();
      n = 0;
      while (gi_log.size() == prev && n < 20) begin tick(); n++; end
      chk("tbl_grant_seen", 64'(gi_log.size()), 64'(prev + 1));
      if (gi_log.size() > prev) chk("tbl_grant", 64'(gi_log[prev]), 64'(vecs[r].exp_grant));
      run_until_idle(30, "tbl");
    end
    keep_only = 0;

    // all four ports contend with two 2-beat frames each
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < S; p++) push_frame(p, 2, 64'(p*256 + f*16), 8'hFF, 0);
    run_until_idle(200, "contend");
    chk("contend_grants", 64'(gi_log.size()), 64'(8));
    for (int k = 0; k < gi_log.size() && k < 8; k++) chk("contend_order", 64'(gi_log[k]), 64'(k % S));

    // output backpressure toggling every cycle
    do_reset();
    toggle_mode = 1; tog = 1;
    push_frame(1, 5, 64'h5000, 8'h3F, 0);
    run_until_idle(100, "bp");
    chk("bp_beats", 64'(out_cnt), 64'(5));
    toggle_mode = 0;

    // truncation on the 4-beat instance, followed by another port's frame
    sel4 = 1'b1;
    do_reset();
    push_frame(1, 7, 64'h7000, 8'hFF, 0);
    push_frame(2, 2, 64'h8000, 8'h01, 0);
    run_until_idle(100, "trunc");
    chk("trunc_beats", 64'(out_cnt), 64'(6));
    chk("trunc_pulses", 64'(seen_trunc), 64'(1));
    if (out_log.size() >= 4) begin
      chk("trunc_b4_last", 64'(out_log[3].last), 64'(1));
      chk("trunc_b4_user", 64'(out_log[3].user), 64'(1));
      chk("trunc_b4_data", out_log[3].data, 64'h7003);
    end
    chk("trunc_grants", 64'(gi_log.size()), 64'(2));
    if (gi_log.size() == 2) chk("trunc_next_grant", 64'(gi_log[1]), 64'(2));
    sel4 = 1'b0;

    // reset during beat 2 of a 4-beat frame
    do_reset();
    push_frame(0, 4, 64'h9000, 8'hFF, 0);
    n = 0;
    while (cur_acc < 1 && n < 20) begin tick(); n++; end
    chk("midrst_reach_beat2", 64'(cur_acc), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst_m_tvalid", 64'(mon_valid), 64'(0));
    chk("midrst_s_tready", 64'(mon_rdy), 64'(0));
    rst = 1'b0; s_tvalid = '0;
    reset_model();
    push_frame(0, 1, 64'hA000, 8'hFF, 0);
    push_frame(2, 1, 64'hA200, 8'hFF, 0);
    run_until_idle(30, "midrst");
    if (gi_log.size() > 0) chk("midrst_first_grant", 64'(gi_log[0]), 64'(0));
    chk("midrst_grants", 64'(gi_log.size()), 64'(2));

    // randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel4 = (s == 1);
      do_reset();
      gaps = 1; bp_rand = 1;
      for (int f = 0; f < 30; f++)
        push_frame($urandom_range(0, S-1), $urandom_range(1, sel4 ? 7 : 20), 64'(0), 8'hFF, 1);
      run_until_idle(5000, "random");
      gaps = 0; bp_rand = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
